// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx_frame
// Brief   : PS/2 device-to-host receiver: pin sync, clock deglitch, 11-bit
//           frame deframing with watchdog. Optional macro
//           PS2_RX_PARITY_CHECK_EN enables odd-parity rejection.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_rx_frame #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_dat,
    output logic [7:0] data,
    output logic       R_O,
    output logic       err,
    output logic       busy
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [c_FW-1:0]        r_filt_cnt;
    logic                   r_clk_filt;
    logic                   r_clk_filt_d;
    logic [1:0]             r_state;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [c_TW-1:0]        r_to_cnt;

    logic       w_clk_s;
    logic       w_dat_s;
    logic       w_strobe;
    logic       w_timeout;
    logic       w_stop_ok;
    logic       w_frame_ok;
    logic       w_frame_bad;
    logic [1:0] w_state_next;
    logic [2:0] w_bit_cnt_next;
    logic [7:0] w_shift_next;
    logic [7:0] w_data_next;
    logic       w_ro_next;
    logic       w_err_next;
    logic       w_busy_next;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
    assign w_strobe = r_clk_filt_d & ~r_clk_filt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync   <= '1;
            r_dat_sync   <= '1;
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], PS2_clk};
            r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], PS2_dat};
            r_clk_filt_d <= r_clk_filt;
            // Run length of samples disagreeing with the accepted level
            if (w_clk_s == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_parity;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_parity <= 1'b0;
        else if (w_strobe && r_state == c_ST_PARITY)
            r_parity <= w_dat_s;
    end
    assign w_stop_ok = w_dat_s & (^{r_shift, r_parity});
`else
    assign w_stop_ok = w_dat_s;
`endif

    assign w_timeout = (r_state != c_ST_IDLE) && !w_strobe &&
                       (r_to_cnt == c_TW'(TIMEOUT_CYC - 1));

    // State register and frame datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            if (r_state == c_ST_IDLE || w_strobe || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_frame_ok     = 1'b0;
        w_frame_bad    = 1'b0;
        if (w_timeout) begin
            w_state_next   = c_ST_IDLE;
            w_bit_cnt_next = 3'd0;
        end else if (w_strobe) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_dat_s) begin
                        w_state_next   = c_ST_DATA;
                        w_bit_cnt_next = 3'd0;
                    end
                end
                c_ST_DATA: begin
                    w_shift_next = {w_dat_s, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next   = c_ST_PARITY;
                        w_bit_cnt_next = 3'd0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
                c_ST_PARITY: w_state_next = c_ST_STOP;
                default: begin
                    w_frame_ok   = w_stop_ok;
                    w_frame_bad  = ~w_stop_ok;
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // Output decode, registered below
    always_comb begin
        w_ro_next   = w_frame_ok;
        w_err_next  = w_frame_bad | w_timeout;
        w_busy_next = (w_state_next != c_ST_IDLE);
        w_data_next = w_frame_ok ? r_shift : data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= 8'h00;
            R_O  <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b0;
        end else begin
            data <= w_data_next;
            R_O  <= w_ro_next;
            err  <= w_err_next;
            busy <= w_busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_rx_frame
// Brief   : Directed vector bench for ps2_rx_frame (frames, glitch, watchdog,
//           mid-frame reset).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_rx_frame;

    localparam int c_HALF    = 100;
    localparam int c_TIMEOUT = 2000;

    logic       clk;
    logic       reset;
    logic       PS2_clk;
    logic       PS2_dat;
    logic [7:0] data;
    logic       R_O;
    logic       err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         ro_cnt  = 0;
    int         err_cnt = 0;
    int         viol    = 0;
    logic       prev_ro = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] prev_data = 8'h00;

    ps2_rx_frame #(
        .SYNC_STAGES(2),
        .FILTER_LEN (8),
        .TIMEOUT_CYC(c_TIMEOUT)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .PS2_clk(PS2_clk),
        .PS2_dat(PS2_dat),
        .data   (data),
        .R_O    (R_O),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: counts pulses and flags protocol violations
    always @(negedge clk) begin
        if (reset) begin
            if (R_O) ro_cnt++;
            if (err) err_cnt++;
            if (R_O && err) viol++;
            if ((R_O && prev_ro) || (err && prev_err)) viol++;
            if ((data !== prev_data) && !R_O) viol++;
        end
        prev_ro   = R_O;
        prev_err  = err;
        prev_data = data;
    end

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        int         exp_ro;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par,
                                               input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    // Sends the first n bits of a frame; glitch_bit < 0 means no glitch
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            PS2_dat = bits[i];
            wait_cyc(c_HALF);
            PS2_clk = 1'b0;
            wait_cyc(c_HALF);
            PS2_clk = 1'b1;
            if (i == glitch_bit) begin
                wait_cyc(40);
                PS2_clk = 1'b0;
                wait_cyc(6);
                PS2_clk = 1'b1;
            end
        end
    endtask

    task automatic frame_and_check(input string name, input logic [7:0] d, input logic par,
                                   input logic stp, input int glitch_bit, input int exp_ro,
                                   input int exp_err, input logic [7:0] exp_data);
        int ro0;
        int er0;
        ro0 = ro_cnt;
        er0 = err_cnt;
        send_bits(frame_bits(d, par, stp), 11, glitch_bit);
        PS2_dat = 1'b1;
        wait_cyc(60);
        check({name, " ro"},   ro_cnt - ro0, exp_ro);
        check({name, " err"},  err_cnt - er0, exp_err);
        check({name, " data"}, int'(data), int'(exp_data));
        check({name, " busy"}, int'(busy), 0);
    endtask

    initial begin
        int ro0;
        int er0;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A};
        vecs[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0};
`ifdef PS2_RX_PARITY_CHECK_EN
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'hF0};
        vecs[4] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'hF0};
`else
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1, 0, 8'h1C};
        vecs[4] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h1C};
`endif

        reset   = 1'b0;
        PS2_clk = 1'b1;
        PS2_dat = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(5);
        check("reset data", int'(data), 0);
        check("reset ro",   int'(R_O), 0);
        check("reset err",  int'(err), 0);
        check("reset busy", int'(busy), 0);

        for (int v = 0; v < 5; v++)
            frame_and_check($sformatf("vec%0d", v), vecs[v].d, vecs[v].par, vecs[v].stp,
                            -1, vecs[v].exp_ro, vecs[v].exp_err, vecs[v].exp_data);

        // Short low glitch on PS2_clk during bit 3 must not add a bit
        frame_and_check("glitch", 8'h5A, 1'b1, 1'b1, 3, 1, 0, 8'h5A);

        // Partial frame then idle: watchdog fires
        ro0 = ro_cnt;
        er0 = err_cnt;
        send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 5, -1);
        PS2_dat = 1'b1;
        wait_cyc(1700);
        check("to early err",  err_cnt - er0, 0);
        check("to early busy", int'(busy), 1);
        wait_cyc(500);
        check("to err",  err_cnt - er0, 1);
        check("to ro",   ro_cnt - ro0, 0);
        check("to busy", int'(busy), 0);
        check("to data", int'(data), 8'h5A);
        frame_and_check("after to", 8'h29, 1'b0, 1'b1, -1, 1, 0, 8'h29);

        // Reset after start + 5 data bits
        ro0 = ro_cnt;
        er0 = err_cnt;
        send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 6, -1);
        wait_cyc(20);
        reset = 1'b0;
        #1;
        check("rst data", int'(data), 0);
        check("rst busy", int'(busy), 0);
        check("rst ro",   int'(R_O), 0);
        check("rst err",  int'(err), 0);
        PS2_dat = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(50);
        check("rst no ro",  ro_cnt - ro0, 0);
        check("rst no err", err_cnt - er0, 0);
        frame_and_check("after rst", 8'h1C, 1'b0, 1'b1, -1, 1, 0, 8'h1C);

        check("strobe rules", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
